// File: rtl/romulus_ctrl_pkg.sv
// Shared encodings for the Romulus-N x4 control sequencer: command ops, FSM states, timing defaults.
package romulus_ctrl_pkg;

  localparam int CIPHER_CYC_DEF = 10;
  localparam int WORDS_DEF      = 4;

  typedef enum logic [2:0] {
    OP_LOAD_KEY   = 3'd0,
    OP_LOAD_NONCE = 3'd1,
    OP_ABSORB     = 3'd2,
    OP_CIPHER     = 3'd3,
    OP_TAG        = 3'd4,
    OP_CLR_STATE  = 3'd5,
    OP_CLR_CNT    = 3'd6,
    OP_NOP        = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LDK  = 4'd1,
    LDN  = 4'd2,
    ABS  = 4'd3,
    INIT = 4'd4,
    RND  = 4'd5,
    RST  = 4'd6,
    OUT  = 4'd7,
    CLR  = 4'd8
  } state_e;

endpackage

// File: rtl/romulus_mode_ctrl_x4_word_hs_cnt.sv
// Block word counter: counts accepted words, flags the last one, wraps to 0 on it.
// Zero latency on last_o (decoded from the registered count); advances only on xfer_i.
module word_hs_cnt #(
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic xfer_i,
  output logic last_o
);

  logic [1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == 2'(WORDS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (xfer_i) cnt_d = last_o ? 2'd0 : cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/romulus_mode_ctrl_x4.sv
// Control sequencer for the 4-round-unrolled Romulus-N datapath; CIPHER takes CIPHER_CYC+2 cycles.
// Word states stall without counting when the active handshake is not completing.
module romulus_mode_ctrl_x4
  import romulus_ctrl_pkg::*;
#(
  parameter int CIPHER_CYC = CIPHER_CYC_DEF,
  parameter int WORDS      = WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_emit,
  input  logic [3:0] cmd_decrypt,
  input  logic [7:0] cmd_domain,
  input  logic       cmd_inc,
  output logic       done,
  input  logic       pdi_valid,
  output logic       pdi_ready,
  input  logic       sdi_valid,
  output logic       sdi_ready,
  output logic       pdo_valid,
  input  logic       pdo_ready,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       erst,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [7:0] domain,
  output logic [3:0] decrypt
);

  localparam int CW = (CIPHER_CYC > 1) ? $clog2(CIPHER_CYC) : 1;

  state_e      state_q;
  op_e         op_q;
  logic        emit_q, inc_q;
  logic [7:0]  domain_q;
  logic [3:0]  dec_q;
  logic [CW-1:0] cyc_q;
  logic        xfer, last;

  word_hs_cnt #(.WORDS(WORDS)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .xfer_i (xfer),
    .last_o (last)
  );

  assign domain = domain_q;
  assign xrst   = 1'b0;
  assign yrst   = 1'b0;

  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    pdi_ready   = 1'b0;
    sdi_ready   = 1'b0;
    pdo_valid   = 1'b0;
    srst        = 1'b0;
    senc        = 1'b0;
    sse         = 1'b0;
    xenc        = 1'b0;
    xse         = 1'b0;
    yenc        = 1'b0;
    yse         = 1'b0;
    zrst        = 1'b0;
    zenc        = 1'b0;
    zse         = 1'b0;
    erst        = 1'b0;
    correct_cnt = 1'b0;
    tk1s        = 1'b0;
    decrypt     = 4'd0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      LDK: begin
        sdi_ready = 1'b1;
        xfer      = sdi_valid;
        xse       = xfer;
        done      = xfer & last;
      end
      LDN: begin
        pdi_ready = 1'b1;
        xfer      = pdi_valid;
        yse       = xfer;
        done      = xfer & last;
      end
      ABS: begin
        // With emit the pdi and pdo words move together, so each side waits on the other.
        decrypt   = dec_q;
        pdi_ready = emit_q ? pdo_ready : 1'b1;
        pdo_valid = emit_q & pdi_valid;
        xfer      = pdi_valid & (~emit_q | pdo_ready);
        sse       = xfer;
        done      = xfer & last;
      end
      INIT: erst = 1'b1;
      RND: begin
        senc = 1'b1;
        xenc = 1'b1;
        yenc = 1'b1;
        zenc = 1'b1;
      end
      RST: begin
        tk1s        = 1'b1;
        xse         = 1'b1;
        yse         = 1'b1;
        zse         = 1'b1;
        correct_cnt = inc_q;
        done        = 1'b1;
      end
      OUT: begin
        pdo_valid = 1'b1;
        xfer      = pdo_ready;
        sse       = xfer;
        done      = xfer & last;
      end
      CLR: begin
        srst = (op_q == OP_CLR_STATE);
        zrst = (op_q == OP_CLR_CNT);
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      emit_q   <= 1'b0;
      inc_q    <= 1'b0;
      domain_q <= 8'd0;
      dec_q    <= 4'd0;
      cyc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q     <= op_e'(cmd_op);
          emit_q   <= cmd_emit;
          inc_q    <= cmd_inc;
          domain_q <= cmd_domain;
          dec_q    <= cmd_decrypt;
          case (op_e'(cmd_op))
            OP_LOAD_KEY:   state_q <= LDK;
            OP_LOAD_NONCE: state_q <= LDN;
            OP_ABSORB:     state_q <= ABS;
            OP_CIPHER:     state_q <= INIT;
            OP_TAG:        state_q <= OUT;
            default:       state_q <= CLR;
          endcase
        end
        LDK, LDN, ABS, OUT: if (xfer && last) state_q <= IDLE;
        INIT: begin
          state_q <= RND;
          cyc_q   <= '0;
        end
        RND: begin
          if (cyc_q == CW'(CIPHER_CYC - 1)) begin
            state_q <= RST;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        RST, CLR: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_romulus_mode_ctrl_x4.sv
// Directed bench for romulus_mode_ctrl_x4: per-cycle transaction-level model check plus literal checks.
module tb_romulus_mode_ctrl_x4;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_emit, cmd_inc, done;
  logic [2:0] cmd_op;
  logic [3:0] cmd_decrypt, decrypt;
  logic [7:0] cmd_domain, domain;
  logic       pdi_valid, pdi_ready, sdi_valid, sdi_ready, pdo_valid, pdo_ready;
  logic       srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse;
  logic       erst, correct_cnt, tk1s;

  romulus_mode_ctrl_x4 dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_emit(cmd_emit),
    .cmd_decrypt(cmd_decrypt), .cmd_domain(cmd_domain), .cmd_inc(cmd_inc), .done(done),
    .pdi_valid(pdi_valid), .pdi_ready(pdi_ready), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
    .pdo_valid(pdo_valid), .pdo_ready(pdo_ready),
    .srst(srst), .senc(senc), .sse(sse), .xrst(xrst), .xenc(xenc), .xse(xse),
    .yrst(yrst), .yenc(yenc), .yse(yse), .zrst(zrst), .zenc(zenc), .zse(zse),
    .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s), .domain(domain), .decrypt(decrypt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] act_vec;
  assign act_vec = {cmd_ready, done, pdi_ready, sdi_ready, pdo_valid, srst, senc, sse,
                    xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse, erst, correct_cnt,
                    tk1s, domain, decrypt};

  int errs = 0, checks = 0;
  int n_xse = 0, n_yse = 0, n_sse = 0, n_done = 0, n_enc = 0, n_erst = 0, n_cc = 0, n_dec = 0;
  bit mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: one command in flight, tracked by cycles since acceptance and words moved.
  bit         m_busy = 0, m_emit = 0, m_inc = 0;
  int         m_op = 0, m_k = 0, m_words = 0;
  logic [7:0] m_dom = 8'd0;
  logic [3:0] m_dec = 4'd0;
  logic e_rdy, e_done, e_pdir, e_sdir, e_pdov, e_srst, e_senc, e_sse, e_xenc, e_xse;
  logic e_yenc, e_yse, e_zrst, e_zenc, e_zse, e_erst, e_cc, e_tk1s, m_xfer;
  logic [3:0] e_dec;

  always @(negedge clk) begin
    if (mon_en) begin
      {e_rdy, e_done, e_pdir, e_sdir, e_pdov, e_srst, e_senc, e_sse, e_xenc, e_xse} = '0;
      {e_yenc, e_yse, e_zrst, e_zenc, e_zse, e_erst, e_cc, e_tk1s, m_xfer} = '0;
      e_dec = 4'd0;
      if (!m_busy) e_rdy = 1'b1;
      else case (m_op)
        0: begin e_sdir = 1; m_xfer = sdi_valid; e_xse = m_xfer; end
        1: begin e_pdir = 1; m_xfer = pdi_valid; e_yse = m_xfer; end
        2: begin
          e_dec  = m_dec;
          e_pdir = m_emit ? pdo_ready : 1'b1;
          e_pdov = m_emit && pdi_valid;
          m_xfer = pdi_valid && (!m_emit || pdo_ready);
          e_sse  = m_xfer;
        end
        3: begin
          e_erst = (m_k == 1);
          if (m_k >= 2 && m_k <= 11) {e_senc, e_xenc, e_yenc, e_zenc} = 4'hF;
          if (m_k == 12) begin
            {e_tk1s, e_xse, e_yse, e_zse, e_done} = 5'h1F;
            e_cc = m_inc;
          end
        end
        4: begin e_pdov = 1; m_xfer = pdo_ready; e_sse = m_xfer; end
        default: begin e_done = 1; e_srst = (m_op == 5); e_zrst = (m_op == 6); end
      endcase
      if (m_xfer && m_words == 3) e_done = 1'b1;
      chk("outputs", act_vec, {e_rdy, e_done, e_pdir, e_sdir, e_pdov, e_srst, e_senc, e_sse,
                               1'b0, e_xenc, e_xse, 1'b0, e_yenc, e_yse, e_zrst, e_zenc, e_zse,
                               e_erst, e_cc, e_tk1s, m_dom, e_dec});
      n_xse  += int'(xse);
      n_yse  += int'(yse);
      n_sse  += int'(sse);
      n_done += int'(done);
      n_enc  += int'(senc);
      n_erst += int'(erst);
      n_cc   += int'(correct_cnt);
      n_dec  += int'(decrypt == 4'hF);
      if (rst) begin
        m_busy = 0; m_dom = 8'd0; m_dec = 4'd0; m_emit = 0; m_inc = 0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_op = int'(cmd_op); m_k = 1; m_words = 0;
          m_dom = cmd_domain; m_dec = cmd_decrypt; m_emit = cmd_emit; m_inc = cmd_inc;
        end
      end else begin
        m_k++;
        if (m_xfer) m_words = (m_words + 1) % 4;
        if (e_done) m_busy = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hs();
    pdi_valid = 0; sdi_valid = 0; pdo_ready = 0;
  endtask

  task automatic set_hs(input int mode, input int lat);
    case (mode)
      1: sdi_valid = lat[0];
      2: begin pdi_valid = 1; pdo_ready = (lat > 3); end
      3: pdo_ready = lat[0];
      4: pdi_valid = 1;
      default: ;
    endcase
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic emit, input logic [3:0] dec,
                         input logic [7:0] dom, input logic inc, input int mode, output int lat);
    bit got;
    chk("accept_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_op = op; cmd_emit = emit; cmd_decrypt = dec; cmd_domain = dom; cmd_inc = inc;
    step();
    cmd_valid = 0;
    lat = 0;
    got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      lat = i;
      clr_hs();
      set_hs(mode, i);
      #1;
      if (done) got = 1;
      else step();
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    step();
    clr_hs();
  endtask

  int lat, b0, b1, b2;

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_emit = 0; cmd_decrypt = 0; cmd_domain = 0; cmd_inc = 0;
    clr_hs();
    step();
    mon_en = 1;
    step();
    chk("reset_vec", act_vec, 32'h8000_0000);
    rst = 0;
    step();

    b0 = n_xse;
    run_cmd(3'd0, 0, 4'h0, 8'h00, 0, 1, lat);
    chk("ldk_latency", lat, 32'd7);
    chk("ldk_xse_count", n_xse - b0, 32'd4);

    b0 = n_yse;
    run_cmd(3'd1, 0, 4'h0, 8'h00, 0, 4, lat);
    chk("ldn_latency", lat, 32'd4);
    chk("ldn_yse_count", n_yse - b0, 32'd4);

    b0 = n_enc; b1 = n_erst; b2 = n_cc;
    run_cmd(3'd3, 0, 4'h0, 8'h2C, 1, 0, lat);
    chk("cipher_latency", lat, 32'd12);
    chk("cipher_enc_cycles", n_enc - b0, 32'd10);
    chk("cipher_erst_cycles", n_erst - b1, 32'd1);
    chk("cipher_correct_cnt", n_cc - b2, 32'd1);
    chk("cipher_domain", {24'b0, domain}, 32'h2C);

    b0 = n_sse; b1 = n_dec;
    run_cmd(3'd2, 1, 4'hF, 8'h2C, 0, 2, lat);
    chk("abs_latency", lat, 32'd7);
    chk("abs_sse_count", n_sse - b0, 32'd4);
    chk("abs_decrypt_cycles", n_dec - b1, 32'd7);
    chk("abs_decrypt_after", {28'b0, decrypt}, 32'h0);

    b0 = n_sse;
    run_cmd(3'd4, 0, 4'h0, 8'h2C, 0, 3, lat);
    chk("tag_latency", lat, 32'd7);
    chk("tag_sse_count", n_sse - b0, 32'd4);
    chk("tag_ready_after", {31'b0, cmd_ready}, 32'd1);

    // Abort a CIPHER in the middle of its rounds.
    cmd_valid = 1; cmd_op = 3'd3; cmd_domain = 8'h11; cmd_inc = 0;
    step();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rnd_senc", {31'b0, senc}, 32'd1);
    b0 = n_done;
    rst = 1;
    step();
    rst = 0;
    chk("abort_vec", act_vec, 32'h8000_0000);
    step();
    chk("abort_no_done", n_done - b0, 32'd0);
    run_cmd(3'd3, 0, 4'h0, 8'h5A, 0, 0, lat);
    chk("cipher_after_abort", lat, 32'd12);

    // Back-to-back clears with cmd_valid held high.
    cmd_valid = 1; cmd_op = 3'd5;
    step();
    chk("clr_state_pulse", {29'b0, srst, done, zrst}, 32'b110);
    cmd_op = 3'd6;
    step();
    chk("clr_second_accept", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 0;
    chk("clr_cnt_pulse", {29'b0, srst, done, zrst}, 32'b011);
    step();
    chk("clr_idle_after", {29'b0, srst, zrst, cmd_ready}, 32'b001);

    b0 = n_done;
    run_cmd(3'd7, 0, 4'h0, 8'h00, 0, 0, lat);
    chk("nop_latency", lat, 32'd1);
    chk("nop_done_count", n_done - b0, 32'd1);

    step();
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
